binary_div_seq: RTL

//  Sequential unsigned restoring divider; inverse of the 4-bit array multiplier: computes Q = A / B, R = A % B.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 32 +++
 rtl/binary_div_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - default operand width and the matching iteration-counter width
//   - helper that sizes the iteration counter for any legal WIDTH (2..16)
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  // Counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem      in  WIDTH+1  partial remainder before the step (always < divisor)
//   quo_msb  in  1        next dividend bit shifted into the remainder
//   divisor  in  WIDTH    captured divisor
//   next_rem out WIDTH+1  partial remainder after the step
//   q_bit    out 1        resolved quotient bit
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  // One extra bit above the shifted remainder so the compare never wraps.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  always_comb begin
    w_shift  = {rem, quo_msb};
    q_bit    = (w_shift >= {2'b00, divisor});
    w_diff   = w_shift - {2'b00, divisor};
    // Result is always < divisor, so truncation to WIDTH+1 bits is lossless.
    next_rem = (WIDTH+1)'(q_bit ? w_diff : w_shift);
  end

endmodule

// File: rtl/binary_div_seq.sv
// Sequential unsigned restoring divider: Q = A / B, R = A % B, one quotient
// bit per clock, with a start/done handshake.
// Optional simulation self-check enabled by defining DIV_SELFCHECK_EN.
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   start        in   1      request, honoured only in IDLE or DONE
//   A, B         in   WIDTH  dividend / divisor, captured on the accepting edge
//   Q, R         out  WIDTH  quotient / remainder, held until the next result
//   busy         out  1      division in progress
//   done         out  1      one-cycle result-valid pulse
//   div_by_zero  out  1      result came from B == 0 (held like Q)
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | resolving one quotient bit per clock
// DONE  | results valid for this cycle; start here is accepted back-to-back
module binary_div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic [WIDTH:0]   w_next_rem;
  logic             w_q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .quo_msb  (r_quo[WIDTH-1]),
    .divisor  (r_div),
    .next_rem (w_next_rem),
    .q_bit    (w_q_bit)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        done = (r_state == ST_DONE);
        if (start) begin
          w_accept    = 1'b1;
          // Zero divisor skips the iterations and reports immediately.
          w_state_nxt = (B == '0) ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_quo <= A;
      r_rem <= '0;
      r_div <= B;
      if (B == '0) begin
        r_q   <= '1;
        r_r   <= A;
        r_dbz <= 1'b1;
      end
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_next_rem;
      r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
      // Results are published only on the edge that enters DONE.
      if (w_last) begin
        r_q   <= {r_quo[WIDTH-2:0], w_q_bit};
        r_r   <= WIDTH'(w_next_rem);
        r_dbz <= 1'b0;
      end
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;

`ifdef DIV_SELFCHECK_EN
  logic [WIDTH-1:0] r_a_chk;

  always_ff @(posedge clk) begin
    if (rst) r_a_chk <= '0;
    else if (w_accept) r_a_chk <= A;
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_DONE && !r_dbz) begin
      if (((2*WIDTH)'(r_q) * (2*WIDTH)'(r_div) + (2*WIDTH)'(r_r)) != (2*WIDTH)'(r_a_chk)
          || r_r >= r_div)
        $error("binary_div_seq: A=%0d B=%0d gave Q=%0d R=%0d", r_a_chk, r_div, r_q, r_r);
    end
  end
`endif

endmodule
